// File: rtl/bin2bcd_pkg.sv
// Shared state encoding and constants for the bin2bcd_seq shift-and-add-3 converter.
package bin2bcd_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // All-nines BCD pattern occupying the low 'digits' nibbles (up to 16 digits).
    function automatic logic [63:0] bcd_nines(input int digits);
        logic [63:0] pat;
        pat = 64'd0;
        for (int i = 0; i < 16; i++) begin
            if (i < digits) begin
                pat[i*NIB_W +: NIB_W] = 4'd9;
            end else begin
                pat[i*NIB_W +: NIB_W] = 4'd0;
            end
        end
        return pat;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_adj3.sv
// Combinational double-dabble nibble correction: values of 5 or more get 3 added.
module bcd_adj3
    import bin2bcd_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [NIB_W-1:0] adj
);

    // Pre-shift correction so the following doubling carries into the next decade.
    always_comb begin
        if (nib >= 4'd5) begin
            adj = nib + 4'd3;
        end else begin
            adj = nib;
        end
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble), one bit per cycle.
// Optional macro BIN2BCD_SAT_EN: saturate bcd to all nines when the value overflows.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int BIN_W  = 14,
    parameter int DIGITS = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [BIN_W-1:0]          bin,
    output logic                      busy,
    output logic                      done,
    output logic [NIB_W*DIGITS-1:0]   bcd,
    output logic                      overflow
);

    localparam int SCR_W = (DIGITS + 1) * NIB_W;
    localparam int OUT_W = NIB_W * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BIN_W - 1);

    state_t             state_r;
    logic [SCR_W-1:0]   scratch_r;
    logic [SCR_W-1:0]   adj_s;
    logic [SCR_W-1:0]   scratch_next_s;
    logic [BIN_W-1:0]   shift_r;
    logic [CNT_W-1:0]   cnt_r;
    logic               ovf_s;
    logic [OUT_W-1:0]   result_s;

    genvar g;
    generate
        for (g = 0; g <= DIGITS; g++) begin : g_adj
            bcd_adj3 u_adj (
                .nib (scratch_r[g*NIB_W +: NIB_W]),
                .adj (adj_s[g*NIB_W +: NIB_W])
            );
        end
    endgenerate

    assign scratch_next_s = {adj_s[SCR_W-2:0], shift_r[BIN_W-1]};

    // Result taken from the scratch value produced by the final shift.
    always_comb begin
        ovf_s = |scratch_next_s[SCR_W-1 -: NIB_W];
`ifdef BIN2BCD_SAT_EN
        if (ovf_s) begin
            result_s = OUT_W'(bcd_nines(DIGITS));
        end else begin
            result_s = scratch_next_s[OUT_W-1:0];
        end
`else
        result_s = scratch_next_s[OUT_W-1:0];
`endif
    end

    // Control FSM and datapath; outputs load on the last shift so they appear with done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r   <= IDLE;
            scratch_r <= {SCR_W{1'b0}};
            shift_r   <= {BIN_W{1'b0}};
            cnt_r     <= {CNT_W{1'b0}};
            busy      <= 1'b0;
            done      <= 1'b0;
            bcd       <= {OUT_W{1'b0}};
            overflow  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        shift_r   <= bin;
                        scratch_r <= {SCR_W{1'b0}};
                        cnt_r     <= {CNT_W{1'b0}};
                        busy      <= 1'b1;
                        state_r   <= SHIFT;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                SHIFT: begin
                    scratch_r <= scratch_next_s;
                    shift_r   <= {shift_r[BIN_W-2:0], 1'b0};
                    cnt_r     <= cnt_r + CNT_W'(1);
                    if (cnt_r == LAST_CNT) begin
                        bcd      <= result_s;
                        overflow <= ovf_s;
                        done     <= 1'b1;
                        state_r  <= DONE;
                    end else begin
                        done <= 1'b0;
                    end
                end
                DONE: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done    <= 1'b0;
                    busy    <= 1'b0;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
